// File: rtl/fas_pkg.sv
// Shared constants and state type for the FAS frame scheduler and its buffer.
package fas_pkg;

    // FIR output sample width (8.8 fixed point)
    localparam int FAS_DW         = 16;
    // Samples per FFT frame; must be a power of two
    localparam int FAS_FRAME_LEN  = 16;
    // Frames per analysis run
    localparam int FAS_NUM_FRAMES = 64;

    // Top-level sequencing of one run
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ANALYZE = 2'd1,
        ST_FINISH  = 2'd2
    } fas_state_t;

endpackage

// File: rtl/fas_pingpong_ram.sv
// Two-bank frame buffer: one write port, one registered read port.
// The bank select forms the top address bit so both banks share one array.
module fas_pingpong_ram #(
    parameter int  DW    = 16,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:2*DEPTH-1];

    // Sample storage; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Registered read; output register clears so the port reads 0 out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/fas_frame_scheduler.sv
// FAS frame scheduler: packs FIR samples into ping-pong frames, launches the
// FFT engine per full frame, counts finished frames, then hands off to analysis.
module fas_frame_scheduler
    import fas_pkg::*;
#(
    parameter int  DW            = FAS_DW,
    parameter int  FRAME_LEN     = FAS_FRAME_LEN,
    parameter int  NUM_FRAMES    = FAS_NUM_FRAMES,
    localparam int IDX_W         = $clog2(FRAME_LEN),
    localparam int FCNT_W        = $clog2(NUM_FRAMES) + 1,
    localparam int TOTAL_SAMPLES = NUM_FRAMES * FRAME_LEN,
    localparam int SCNT_W        = $clog2(TOTAL_SAMPLES) + 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              fir_valid,
    input  logic [DW-1:0]     fir_d,
    input  logic [IDX_W-1:0]  fft_rd_addr,
    input  logic              fft_done,
    input  logic              ana_done,
    output logic              fft_start,
    output logic              fft_bank,
    output logic [DW-1:0]     fft_rd_data,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              ana_start,
    output logic              done,
    output logic              overflow
);

    fas_state_t         state;
    logic               wr_bank;
    logic [IDX_W-1:0]   wr_idx;
    logic               rd_bank;
    logic               busy;
    logic [1:0]         full;
    logic [SCNT_W-1:0]  sample_cnt;

    logic               accept_window;
    logic               wr_en;
    logic               drop;
    logic               frame_end;
    logic               launch;
    logic               retire;
    logic               last_frame;

    // Accept only during RUN and until a full run's worth of samples has been stored.
    assign accept_window = (state == ST_RUN) && (sample_cnt < SCNT_W'(TOTAL_SAMPLES));
    // Full flags are looked at before any same-cycle clear from fft_done, so a
    // sample aimed at a bank being released this cycle is still dropped.
    assign wr_en      = fir_valid && accept_window && !full[wr_bank];
    assign drop       = fir_valid && accept_window &&  full[wr_bank];
    assign frame_end  = wr_en && (wr_idx == IDX_W'(FRAME_LEN - 1));
    assign launch     = !busy && full[rd_bank];
    assign retire     = busy && fft_done;
    assign last_frame = retire && (frame_cnt == FCNT_W'(NUM_FRAMES - 1));

    // Per-bank full flags: set when the last sample of a frame lands, cleared when
    // the engine retires that bank. A bank is never set and cleared together,
    // because writes only target a bank that is not full.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    full[gi] <= 1'b0;
                end else if (frame_end && (wr_bank == 1'(gi))) begin
                    full[gi] <= 1'b1;
                end else if (retire && (rd_bank == 1'(gi))) begin
                    full[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Write pointer, accepted-sample count and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                sample_cnt <= sample_cnt + SCNT_W'(1);
                if (frame_end) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Engine handshake: launch a full bank when idle, retire it on fft_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fft_start <= 1'b0;
            fft_bank  <= 1'b0;
            busy      <= 1'b0;
            rd_bank   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            fft_start <= launch;
            if (launch) begin
                fft_bank <= rd_bank;
                busy     <= 1'b1;
            end
            if (retire) begin
                busy    <= 1'b0;
                rd_bank <= ~rd_bank;
                if (frame_cnt != FCNT_W'(NUM_FRAMES)) begin
                    frame_cnt <= frame_cnt + FCNT_W'(1);
                end
            end
        end
    end

    // Run sequencing with registered ana_start pulse and sticky done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            ana_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            ana_start <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (last_frame) begin
                        state     <= ST_ANALYZE;
                        ana_start <= 1'b1;
                    end
                end
                ST_ANALYZE: begin
                    if (ana_done) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    fas_pingpong_ram #(
        .DW    (DW),
        .DEPTH (FRAME_LEN)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_idx),
        .wr_data (fir_d),
        .rd_bank (fft_bank),
        .rd_addr (fft_rd_addr),
        .rd_data (fft_rd_data)
    );

endmodule

// File: tb/tb_fas_frame_scheduler.sv
// Bench for fas_frame_scheduler: frame-level reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_fas_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        fir_valid;
    logic [15:0] fir_d;
    logic [3:0]  fft_rd_addr;
    logic        fft_done;
    logic        ana_done;
    logic        fft_start;
    logic        fft_bank;
    logic [15:0] fft_rd_data;
    logic [6:0]  frame_cnt;
    logic        ana_start;
    logic        done;
    logic        overflow;

    always #5 clk = ~clk;

    fas_frame_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .fir_valid   (fir_valid),
        .fir_d       (fir_d),
        .fft_rd_addr (fft_rd_addr),
        .fft_done    (fft_done),
        .ana_done    (ana_done),
        .fft_start   (fft_start),
        .fft_bank    (fft_bank),
        .fft_rd_data (fft_rd_data),
        .frame_cnt   (frame_cnt),
        .ana_start   (ana_start),
        .done        (done),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame / occupancy level) ----------------
    // Occupancy = frames waiting for launch + frame in the engine; both banks are
    // taken when it reaches 2. Banks are assigned by frame number parity.
    int          m_pend, m_busy, m_filled, m_launched, m_idx, m_acc, m_frames, m_phase;
    int          phase_pre, occ_pre;
    bit          add_frame;
    bit          m_ovf, m_done, m_bank, e_start, e_ana, e_rd_chk;
    logic [15:0] e_rd;
    logic [15:0] m_mem [2][16];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_busy = 0; m_filled = 0; m_launched = 0; m_idx = 0;
            m_acc = 0; m_frames = 0; m_phase = 0;
            m_ovf = 0; m_done = 0; m_bank = 0; e_start = 0; e_ana = 0; e_rd_chk = 0;
            e_rd = '0;
        end else begin
            phase_pre = m_phase;
            occ_pre   = m_pend + m_busy;
            add_frame = 0;
            e_rd_chk  = (m_busy != 0);
            e_rd      = m_mem[m_bank][fft_rd_addr];
            if (m_phase == 0 && fir_valid && m_acc < 1024) begin
                if (occ_pre == 2) begin
                    m_ovf = 1;
                end else begin
                    m_mem[m_filled % 2][m_idx] = fir_d;
                    m_acc++;
                    if (m_idx == 15) begin
                        m_idx = 0;
                        m_filled++;
                        add_frame = 1;
                    end else begin
                        m_idx++;
                    end
                end
            end
            e_start = 0;
            e_ana   = 0;
            if (m_busy != 0 && fft_done) begin
                m_busy = 0;
                if (m_frames < 64) m_frames++;
                if (m_phase == 0 && m_frames == 64) begin
                    m_phase = 1;
                    e_ana   = 1;
                end
            end else if (m_busy == 0 && m_pend > 0) begin
                m_busy  = 1;
                m_pend--;
                m_bank  = ((m_launched % 2) == 1);
                m_launched++;
                e_start = 1;
            end
            if (add_frame) m_pend++;
            if (phase_pre == 1 && ana_done) begin
                m_phase = 2;
                m_done  = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_start = 0;
    int n_ana   = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("fft_start", int'(fft_start), int'(e_start));
            check("fft_bank",  int'(fft_bank),  int'(m_bank));
            check("frame_cnt", int'(frame_cnt), m_frames);
            check("ana_start", int'(ana_start), int'(e_ana));
            check("done",      int'(done),      int'(m_done));
            check("overflow",  int'(overflow),  int'(m_ovf));
            if (e_rd_chk) check("fft_rd_data", int'(fft_rd_data), int'(e_rd));
            if (fft_start) n_start++;
            if (ana_start) n_ana++;
        end
    end

    // ---------------- stimulus ----------------
    int eng_auto = 0;
    int eng_lat  = 12;
    int eng_cnt  = 0;

    // Drive one cycle of inputs, emulating the FFT engine when eng_auto is set,
    // then advance to just after the next rising edge.
    task automatic tick(input bit v, input logic [15:0] d, input bit mdone);
        fft_done = mdone;
        if (eng_auto != 0) begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) fft_done = 1'b1;
            end
            if (fft_start) eng_cnt = eng_lat;
        end
        fir_valid = v;
        fir_d     = d;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release after an edge.
    task automatic reset_and_check(input string tag);
        rst       = 1'b0;
        eng_cnt   = 0;
        fir_valid = 1'b0;
        fft_done  = 1'b0;
        ana_done  = 1'b0;
        #2;
        check({tag, "_rst_fft_start"}, int'(fft_start),   0);
        check({tag, "_rst_fft_bank"},  int'(fft_bank),    0);
        check({tag, "_rst_rd_data"},   int'(fft_rd_data), 0);
        check({tag, "_rst_frame_cnt"}, int'(frame_cnt),   0);
        check({tag, "_rst_ana_start"}, int'(ana_start),   0);
        check({tag, "_rst_done"},      int'(done),        0);
        check({tag, "_rst_overflow"},  int'(overflow),    0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int s_start, s_ana;

    initial begin
        rst = 1'b1; fir_valid = 1'b0; fir_d = '0; fft_rd_addr = '0;
        fft_done = 1'b0; ana_done = 1'b0;
        #1;

        // T1: one frame 0x0100..0x010F, launch on bank 0, read index 5
        reset_and_check("t1");
        eng_auto = 0;
        for (int i = 0; i < 16; i++) tick(1'b1, 16'h0100 + 16'(i), 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        check("t1_fft_start", int'(fft_start), 1);
        check("t1_fft_bank",  int'(fft_bank),  0);
        fft_rd_addr = 4'd5;
        tick(1'b0, 16'h0, 1'b0);
        check("t1_rd_data", int'(fft_rd_data), 16'h0105);
        $display("T1 single frame launch/readback done");

        // T2: full run at full input rate; engine answers within 14 cycles so
        // the next frame never collides with a still-busy bank
        reset_and_check("t2");
        eng_auto = 1; eng_lat = 12;
        s_start = n_start; s_ana = n_ana;
        for (int i = 0; i < 1024; i++) tick(1'b1, 16'(i * 3), 1'b0);
        for (int i = 0; i < 40; i++) tick(1'b0, 16'h0, 1'b0);
        check("t2_launches", n_start - s_start, 64);
        check("t2_ana_pulses", n_ana - s_ana, 1);
        check("t2_frame_cnt", int'(frame_cnt), 64);
        check("t2_overflow", int'(overflow), 0);
        check("t2_done_before", int'(done), 0);
        ana_done = 1'b1;
        tick(1'b0, 16'h0, 1'b0);
        ana_done = 1'b0;
        check("t2_done_after", int'(done), 1);
        $display("T2 full run done");

        // T3: engine stalls, both banks fill, 33rd sample overflows
        reset_and_check("t3");
        eng_auto = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 16'h0200 + 16'(i), 1'b0);
            if (i == 31) check("t3_ovf_pre", int'(overflow), 0);
            if (i == 32) check("t3_ovf_post", int'(overflow), 1);
        end
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b0);
        check("t3_fft_start", int'(fft_start), 1);
        check("t3_fft_bank",  int'(fft_bank),  1);
        check("t3_frame_cnt", int'(frame_cnt), 1);
        for (int j = 0; j < 16; j++) begin
            fft_rd_addr = 4'(j);
            tick(1'b0, 16'h0, 1'b0);
            check("t3_frame2_data", int'(fft_rd_data), 16'h0210 + j);
        end
        $display("T3 stall/overflow done");

        // T4: fft_done on bank 0 in the same cycle as the 33rd sample
        reset_and_check("t4");
        eng_auto = 0;
        for (int i = 0; i < 49; i++) begin
            tick(1'b1, 16'h0400 + 16'(i), i == 32);
            if (i == 32) check("t4_ovf", int'(overflow), 1);
        end
        tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b0);
        check("t4_fft_start", int'(fft_start), 1);
        check("t4_fft_bank",  int'(fft_bank),  0);
        check("t4_frame_cnt", int'(frame_cnt), 2);
        fft_rd_addr = 4'd0;
        tick(1'b0, 16'h0, 1'b0);
        check("t4_bank0_idx0", int'(fft_rd_data), 16'h0421);
        fft_rd_addr = 4'd15;
        tick(1'b0, 16'h0, 1'b0);
        check("t4_bank0_idx15", int'(fft_rd_data), 16'h0430);
        $display("T4 simultaneous done/write done");

        // T5: reset in the middle of frame 3, then restart from frame 0
        reset_and_check("t5a");
        eng_auto = 1; eng_lat = 12;
        for (int i = 0; i < 42; i++) tick(1'b1, 16'h0500 + 16'(i), 1'b0);
        check("t5_pre_frame_cnt", int'(frame_cnt), 1);
        check("t5_pre_fft_bank",  int'(fft_bank),  1);
        reset_and_check("t5b");
        for (int i = 0; i < 16; i++) tick(1'b1, 16'h0600 + 16'(i), 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        check("t5_fft_start", int'(fft_start), 1);
        check("t5_fft_bank",  int'(fft_bank),  0);
        check("t5_frame_cnt0", int'(frame_cnt), 0);
        for (int i = 0; i < 13; i++) tick(1'b0, 16'h0, 1'b0);
        check("t5_frame_cnt1", int'(frame_cnt), 1);
        $display("T5 mid-run reset done");

        // T6: 1100 samples, excess ignored without overflow
        reset_and_check("t6");
        eng_auto = 1; eng_lat = 12;
        s_ana = n_ana;
        for (int i = 0; i < 1100; i++) tick(1'b1, 16'h8000 ^ 16'(i), 1'b0);
        check("t6_overflow", int'(overflow), 0);
        check("t6_frame_cnt", int'(frame_cnt), 64);
        check("t6_ana_pulses", n_ana - s_ana, 1);
        check("t6_done_before", int'(done), 0);
        ana_done = 1'b1;
        tick(1'b1, 16'h1234, 1'b0);
        ana_done = 1'b0;
        check("t6_done_after", int'(done), 1);
        tick(1'b1, 16'h4321, 1'b0);
        check("t6_done_held", int'(done), 1);
        check("t6_overflow_end", int'(overflow), 0);
        $display("T6 excess samples done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
